// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order ROB retirement stage: dequeue, regfile write, RAT release, halt detect.
// Optional RVFI trace outputs are enabled by defining COMMIT_RVFI_EN.
package commit_pkg;
  localparam int ROB_IDX_W = 5;

  typedef enum logic {
    ROB_WAIT = 1'b0,
    ROB_DONE = 1'b1
  } rob_status_e;

  typedef struct packed {
    logic                 valid;
    rob_status_e          status;
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [4:0]           rd_addr;
    logic [ROB_IDX_W-1:0] rd_rob_idx;
    logic [31:0]          rd_data;
  } rob_entry_t;
endpackage

module commit_unit
  import commit_pkg::*;
#(
  parameter int          ORDER_W   = 64,
  parameter logic [31:0] HALT_INST = 32'h0000_0063
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  rob_entry_t           rob_head_i,
  input  logic                 rob_empty_i,
  input  logic                 stall_i,
  output logic                 dequeue_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_rd_o,
  output logic [31:0]          rf_data_o,
  output logic                 rat_clr_o,
  output logic [4:0]           rat_rd_o,
  output logic [ROB_IDX_W-1:0] rat_idx_o,
  output logic [ORDER_W-1:0]   order_o,
  output logic                 halt_o
`ifdef COMMIT_RVFI_EN
  ,
  output logic                 rvfi_valid_o,
  output logic [ORDER_W-1:0]   rvfi_order_o,
  output logic [31:0]          rvfi_pc_o,
  output logic [31:0]          rvfi_insn_o,
  output logic [4:0]           rvfi_rd_addr_o,
  output logic [31:0]          rvfi_rd_wdata_o
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   w_fire;
  logic   w_is_halt;

  logic                 r_rf_we;
  logic [4:0]           r_rf_rd;
  logic [31:0]          r_rf_data;
  logic                 r_rat_clr;
  logic [4:0]           r_rat_rd;
  logic [ROB_IDX_W-1:0] r_rat_idx;
  logic [ORDER_W-1:0]   r_order;

  // rst_n gating keeps dequeue_o low while reset is held, even with a live head.
  assign w_fire = rst_n && (r_state == S_RUN) && !stall_i && !rob_empty_i &&
                  rob_head_i.valid && (rob_head_i.status == ROB_DONE);
  assign w_is_halt = (rob_head_i.inst == HALT_INST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_fire && w_is_halt) begin
          w_state_nxt = S_HALT;
        end else if (stall_i) begin
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (!stall_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    dequeue_o = w_fire;
    halt_o    = (r_state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
      r_rat_clr <= 1'b0;
      r_rat_rd  <= '0;
      r_rat_idx <= '0;
      r_order   <= '0;
    end else begin
      r_rf_we   <= w_fire && (rob_head_i.rd_addr != 5'd0);
      r_rat_clr <= w_fire;
      if (w_fire) begin
        r_rf_rd   <= rob_head_i.rd_addr;
        r_rf_data <= rob_head_i.rd_data;
        r_rat_rd  <= rob_head_i.rd_addr;
        r_rat_idx <= rob_head_i.rd_rob_idx;
        r_order   <= r_order + 1'b1;
      end
    end
  end

  assign rf_we_o   = r_rf_we;
  assign rf_rd_o   = r_rf_rd;
  assign rf_data_o = r_rf_data;
  assign rat_clr_o = r_rat_clr;
  assign rat_rd_o  = r_rat_rd;
  assign rat_idx_o = r_rat_idx;
  assign order_o   = r_order;

`ifdef COMMIT_RVFI_EN
  logic               r_rvfi_valid;
  logic [ORDER_W-1:0] r_rvfi_order;
  logic [31:0]        r_rvfi_pc;
  logic [31:0]        r_rvfi_insn;
  logic [4:0]         r_rvfi_rd_addr;
  logic [31:0]        r_rvfi_rd_wdata;

  // Trace carries the pre-increment order so the first retired instruction reports 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvfi_valid    <= 1'b0;
      r_rvfi_order    <= '0;
      r_rvfi_pc       <= '0;
      r_rvfi_insn     <= '0;
      r_rvfi_rd_addr  <= '0;
      r_rvfi_rd_wdata <= '0;
    end else begin
      r_rvfi_valid <= w_fire;
      if (w_fire) begin
        r_rvfi_order    <= r_order;
        r_rvfi_pc       <= rob_head_i.pc;
        r_rvfi_insn     <= rob_head_i.inst;
        r_rvfi_rd_addr  <= rob_head_i.rd_addr;
        r_rvfi_rd_wdata <= (rob_head_i.rd_addr == 5'd0) ? 32'd0 : rob_head_i.rd_data;
      end
    end
  end

  assign rvfi_valid_o    = r_rvfi_valid;
  assign rvfi_order_o    = r_rvfi_order;
  assign rvfi_pc_o       = r_rvfi_pc;
  assign rvfi_insn_o     = r_rvfi_insn;
  assign rvfi_rd_addr_o  = r_rvfi_rd_addr;
  assign rvfi_rd_wdata_o = r_rvfi_rd_wdata;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^rob_head_i.pc;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - randomized self-checking bench for commit_unit against a retirement model.
module tb_commit_unit;
  import commit_pkg::*;

  localparam logic [31:0] HALT = 32'h0000_0063;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  rob_entry_t           rob_head_i;
  logic                 rob_empty_i = 1'b1;
  logic                 stall_i = 1'b0;
  logic                 dequeue_o, rf_we_o, rat_clr_o, halt_o;
  logic [4:0]           rf_rd_o, rat_rd_o;
  logic [31:0]          rf_data_o;
  logic [ROB_IDX_W-1:0] rat_idx_o;
  logic [63:0]          order_o;
`ifdef COMMIT_RVFI_EN
  logic        rvfi_valid_o;
  logic [63:0] rvfi_order_o;
  logic [31:0] rvfi_pc_o, rvfi_insn_o, rvfi_rd_wdata_o;
  logic [4:0]  rvfi_rd_addr_o;
`endif

  commit_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rob_head_i  (rob_head_i),
    .rob_empty_i (rob_empty_i),
    .stall_i     (stall_i),
    .dequeue_o   (dequeue_o),
    .rf_we_o     (rf_we_o),
    .rf_rd_o     (rf_rd_o),
    .rf_data_o   (rf_data_o),
    .rat_clr_o   (rat_clr_o),
    .rat_rd_o    (rat_rd_o),
    .rat_idx_o   (rat_idx_o),
    .order_o     (order_o),
    .halt_o      (halt_o)
`ifdef COMMIT_RVFI_EN
    ,
    .rvfi_valid_o    (rvfi_valid_o),
    .rvfi_order_o    (rvfi_order_o),
    .rvfi_pc_o       (rvfi_pc_o),
    .rvfi_insn_o     (rvfi_insn_o),
    .rvfi_rd_addr_o  (rvfi_rd_addr_o),
    .rvfi_rd_wdata_o (rvfi_rd_wdata_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deq   = 0;

  // Reference model: what the registered outputs should show after the next edge.
  logic        m_we, m_clr, m_halt, m_prev_stall;
  logic [4:0]  m_rd, m_rat_rd;
  logic [31:0] m_data;
  logic [4:0]  m_idx;
  logic [63:0] m_order;
  logic        m_rv_valid;
  logic [63:0] m_rv_order;
  logic [31:0] m_rv_pc, m_rv_insn, m_rv_wdata;
  logic [4:0]  m_rv_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_we = 0; m_clr = 0; m_halt = 0; m_prev_stall = 0;
    m_rd = 0; m_rat_rd = 0; m_data = 0; m_idx = 0; m_order = 0;
    m_rv_valid = 0; m_rv_order = 0; m_rv_pc = 0; m_rv_insn = 0; m_rv_wdata = 0; m_rv_rd = 0;
  endtask

  task automatic check_regs();
    check("rf_we", rf_we_o, m_we);
    check("rf_rd", rf_rd_o, m_rd);
    check("rf_data", rf_data_o, m_data);
    check("rat_clr", rat_clr_o, m_clr);
    check("rat_rd", rat_rd_o, m_rat_rd);
    check("rat_idx", rat_idx_o, m_idx);
    check("order", order_o, m_order);
    check("halt", halt_o, m_halt);
`ifdef COMMIT_RVFI_EN
    check("rvfi_valid", rvfi_valid_o, m_rv_valid);
    check("rvfi_order", rvfi_order_o, m_rv_order);
    check("rvfi_pc", rvfi_pc_o, m_rv_pc);
    check("rvfi_insn", rvfi_insn_o, m_rv_insn);
    check("rvfi_rd", rvfi_rd_addr_o, m_rv_rd);
    check("rvfi_wdata", rvfi_rd_wdata_o, m_rv_wdata);
`endif
  endtask

  // One cycle: check last edge's results, drive new head, check dequeue, advance model.
  task automatic step(input rob_entry_t e, input logic emp, input logic stl);
    logic f;
    @(negedge clk);
    check_regs();
    rob_head_i = e; rob_empty_i = emp; stall_i = stl;
    #1;
    // The unit is in RUN only if the previous cycle saw no stall and no halt has retired.
    f = !m_halt && !m_prev_stall && !stl && !emp && e.valid && (e.status == ROB_DONE);
    check("dequeue", dequeue_o, f);
    if (dequeue_o) n_deq++;
    m_prev_stall = stl;
    m_rv_valid = f;
    m_we = f && (e.rd_addr != 0);
    m_clr = f;
    if (f) begin
      m_rv_order = m_order;
      m_rv_pc = e.pc; m_rv_insn = e.inst; m_rv_rd = e.rd_addr;
      m_rv_wdata = (e.rd_addr == 0) ? 32'd0 : e.rd_data;
      m_rd = e.rd_addr; m_rat_rd = e.rd_addr; m_data = e.rd_data; m_idx = e.rd_rob_idx;
      m_order = m_order + 1;
      if (e.inst == HALT) m_halt = 1;
    end
  endtask

  function automatic rob_entry_t mk(input logic v, input rob_status_e s, input logic [4:0] rd,
                                    input logic [31:0] d, input logic [4:0] idx, input logic [31:0] inst);
    rob_entry_t e;
    e.valid = v; e.status = s; e.pc = $urandom; e.inst = inst;
    e.rd_addr = rd; e.rd_rob_idx = idx; e.rd_data = d;
    return e;
  endfunction

  function automatic rob_entry_t rand_entry();
    logic [31:0] inst;
    inst = $urandom;
    if (inst == HALT) inst = inst ^ 32'h1;
    return mk($urandom_range(0, 9) != 0,
              ($urandom_range(0, 9) < 7) ? ROB_DONE : ROB_WAIT,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              $urandom, 5'($urandom), inst);
  endfunction

  task automatic idle();
    step(mk(0, ROB_WAIT, 0, 0, 0, 32'h13), 1'b1, 1'b0);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 0;
    #1;
    check({tag, "_deq"}, dequeue_o, 0);
    check({tag, "_rf_we"}, rf_we_o, 0);
    check({tag, "_rf_rd"}, rf_rd_o, 0);
    check({tag, "_rf_data"}, rf_data_o, 0);
    check({tag, "_rat_clr"}, rat_clr_o, 0);
    check({tag, "_rat_rd"}, rat_rd_o, 0);
    check({tag, "_rat_idx"}, rat_idx_o, 0);
    check({tag, "_order"}, order_o, 0);
    check({tag, "_halt"}, halt_o, 0);
    rob_empty_i = 1; stall_i = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    int d0;
    rob_entry_t e;
    model_reset();
    rob_head_i = mk(0, ROB_WAIT, 0, 0, 0, 32'h13);
    #3;
    reset_now("rst0");

    // Basic retire with known payload.
    step(mk(1, ROB_DONE, 5, 32'hDEAD_BEEF, 3, 32'h0050_0293), 1'b0, 1'b0);
    check("t1_deq", dequeue_o, 1);
    idle();
    check("t1_rf_we", rf_we_o, 1);
    check("t1_rf_rd", rf_rd_o, 5);
    check("t1_rf_data", rf_data_o, 32'hDEAD_BEEF);
    check("t1_rat_idx", rat_idx_o, 3);
    check("t1_order", order_o, 1);

    // Head waits four cycles before completing.
    d0 = n_deq;
    e = mk(1, ROB_WAIT, 7, 32'h1234_5678, 9, 32'h0070_0393);
    repeat (4) step(e, 1'b0, 1'b0);
    check("t2_no_deq_while_wait", n_deq - d0, 0);
    e.status = ROB_DONE;
    step(e, 1'b0, 1'b0);
    idle();
    check("t2_one_write", n_deq - d0, 1);

    // rd = x0 retires without a regfile write.
    step(mk(1, ROB_DONE, 0, 32'hFFFF_0000, 12, 32'h0000_0013), 1'b0, 1'b0);
    idle();
    check("t3_rf_we", rf_we_o, 0);
    check("t3_rat_clr", rat_clr_o, 1);
    check("t3_order", order_o, 3);

    // Stall for three cycles, release, then retire one cycle later.
    d0 = n_deq;
    e = mk(1, ROB_DONE, 9, 32'hCAFE_F00D, 4, 32'h0090_0493);
    repeat (3) step(e, 1'b0, 1'b1);
    step(e, 1'b0, 1'b0);
    check("t4_no_deq_on_release", n_deq - d0, 0);
    step(e, 1'b0, 1'b0);
    check("t4_deq_after_release", dequeue_o, 1);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(rand_entry(), $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0);
    end
    idle();

    // Reset with order at 7 and a retirement in flight.
    @(negedge clk);
    reset_now("rst1");
    for (int i = 0; i < 7; i++) begin
      step(mk(1, ROB_DONE, 5'(i + 1), $urandom, 5'(i), 32'h13), 1'b0, 1'b0);
    end
    step(mk(1, ROB_DONE, 5'd20, 32'h5555_AAAA, 5'd17, 32'h13), 1'b0, 1'b0);
    check("t5_order_before_rst", order_o, 7);
    check("t5_deq_pending", dequeue_o, 1);
    #2;
    reset_now("rst2");
    step(mk(1, ROB_DONE, 6, 32'h0BAD_F00D, 2, 32'h13), 1'b0, 1'b0);
    idle();
    check("t5_order_after_rst", order_o, 1);
    check("t5_rf_data_after_rst", rf_data_o, 32'h0BAD_F00D);

    // Halt retires normally, then nothing else dequeues.
    step(mk(1, ROB_DONE, 0, 0, 8, HALT), 1'b0, 1'b0);
    check("t6_halt_deq", dequeue_o, 1);
    d0 = n_deq;
    for (int i = 0; i < 12; i++) begin
      step(mk(1, ROB_DONE, 5'd3, $urandom, 5'd9, 32'h13), 1'b0, 1'($urandom_range(0, 1)));
    end
    check("t6_no_deq_after_halt", n_deq - d0, 0);
    check("t6_halt_sticky", halt_o, 1);
    check("t6_order", order_o, 2);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
